// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the drum memory unit.
// Holds default geometry (address/data/sector widths, clock divider)
// and the state code reported on the panel.
package mem_pkg;
  localparam int MEM_ADDR_W   = 12;
  localparam int MEM_DATA_W   = 31;
  localparam int MEM_SECTOR_W = 6;
  localparam int MEM_DRUM_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK_RD = 2'd1,
    ST_SEEK_WR = 2'd2,
    ST_RESP    = 2'd3
  } mem_state_e;
endpackage

// File: rtl/drum_timer.sv
// Drum rotation model: a clock divider and a free-running sector counter.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   div_cnt_o         cycle within the current sector (0..DRUM_DIV-1)
//   pos_o             sector currently under the heads
//   sector_start_o    high in the first cycle of each sector
module drum_timer #(
  parameter int SECTOR_W = 6,
  parameter int DRUM_DIV = 4,
  parameter int DIV_W    = (DRUM_DIV > 1) ? $clog2(DRUM_DIV) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [DIV_W-1:0]    div_cnt_o,
  output logic [SECTOR_W-1:0] pos_o,
  output logic                sector_start_o
);
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [SECTOR_W-1:0] pos_q, pos_d;
  logic                last_tick;

  always_comb begin
    last_tick = (div_cnt_q == DIV_W'(DRUM_DIV - 1));
    div_cnt_d = last_tick ? '0 : div_cnt_q + 1'b1;
    // pos wraps naturally at 2^SECTOR_W
    pos_d     = last_tick ? pos_q + 1'b1 : pos_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt_q <= '0;
      pos_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pos_q     <= pos_d;
    end
  end

  assign div_cnt_o      = div_cnt_q;
  assign pos_o          = pos_q;
  assign sector_start_o = (div_cnt_q == '0);
endmodule

// File: rtl/mem_drum_unit.sv
// Drum memory unit: a word array that can only be accessed when the
// addressed sector comes round under the heads. One operation at a time;
// extra requests are dropped and flagged on the panel.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   mem_read_from_pu       read request pulse
//   mem_write_from_op      write request pulse
//   addr_from_sel          word address (sampled with a request)
//   wdata_from_ac          write data (sampled with a write)
//   clear_from_pnl         panel clear: abort operation, clear error flag
//   mem_read_reply_to_pu   read-complete pulse
//   mem_write_done_to_op   write-complete pulse
//   rdata_to_ac            last completed read word
//   busy_to_pnl            operation in progress
//   err_overlap_to_pnl     sticky dropped-request flag
//   state_to_pnl           FSM state code
module mem_drum_unit import mem_pkg::*; #(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int SECTOR_W = MEM_SECTOR_W,
  parameter int DRUM_DIV = MEM_DRUM_DIV
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_read_from_pu,
  input  logic              mem_write_from_op,
  input  logic [ADDR_W-1:0] addr_from_sel,
  input  logic [DATA_W-1:0] wdata_from_ac,
  input  logic              clear_from_pnl,
  output logic              mem_read_reply_to_pu,
  output logic              mem_write_done_to_op,
  output logic [DATA_W-1:0] rdata_to_ac,
  output logic              busy_to_pnl,
  output logic              err_overlap_to_pnl,
  output logic [1:0]        state_to_pnl
);
  localparam int DIV_W = (DRUM_DIV > 1) ? $clog2(DRUM_DIV) : 1;

  logic [DIV_W-1:0]    div_cnt;
  logic [SECTOR_W-1:0] pos;
  logic                sector_start;

  drum_timer #(
    .SECTOR_W (SECTOR_W),
    .DRUM_DIV (DRUM_DIV),
    .DIV_W    (DIV_W)
  ) u_timer (
    .clk            (clk),
    .resetn         (resetn),
    .div_cnt_o      (div_cnt),
    .pos_o          (pos),
    .sector_start_o (sector_start)
  );

  mem_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                is_rd_q, is_rd_d;
  logic                mem_we;
  logic                match;
  logic                any_req;
  logic [DATA_W-1:0]   rd_word;

  logic [DATA_W-1:0]   mem_q [0:(1<<ADDR_W)-1];

  assign rd_word = mem_q[addr_q];
  assign any_req = mem_read_from_pu | mem_write_from_op;
  // Only the first cycle of the sector counts, so a request that arrives
  // mid-sector waits a full revolution.
  assign match   = (state_q == ST_SEEK_RD || state_q == ST_SEEK_WR) &&
                   (pos == addr_q[SECTOR_W-1:0]) && sector_start;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    is_rd_d = is_rd_q;
    mem_we  = 1'b0;
    if (clear_from_pnl) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_read_from_pu) begin
            addr_d  = addr_from_sel;
            is_rd_d = 1'b1;
            state_d = ST_SEEK_RD;
            if (mem_write_from_op) err_d = 1'b1;
          end else if (mem_write_from_op) begin
            addr_d  = addr_from_sel;
            wdata_d = wdata_from_ac;
            is_rd_d = 1'b0;
            state_d = ST_SEEK_WR;
          end
        end
        ST_SEEK_RD: begin
          if (any_req) err_d = 1'b1;
          if (match) begin
            rdata_d = rd_word;
            state_d = ST_RESP;
          end
        end
        ST_SEEK_WR: begin
          if (any_req) err_d = 1'b1;
          if (match) begin
            mem_we  = 1'b1;
            state_d = ST_RESP;
          end
        end
        default: begin
          if (any_req) err_d = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      is_rd_q <= is_rd_d;
    end
  end

  // Array is never reset; a reset in the match cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (resetn && mem_we) mem_q[addr_q] <= wdata_q;
  end

  assign mem_read_reply_to_pu = (state_q == ST_RESP) &&  is_rd_q;
  assign mem_write_done_to_op = (state_q == ST_RESP) && !is_rd_q;
  assign rdata_to_ac          = rdata_q;
  assign busy_to_pnl          = (state_q != ST_IDLE);
  assign err_overlap_to_pnl   = err_q;
  assign state_to_pnl         = state_q;
endmodule

// File: tb/tb_mem_drum_unit.sv
module tb_mem_drum_unit;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 31;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              rd = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              reply, done, busy, err;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        state;

  int vectors = 0;
  int miscompares = 0;

  mem_drum_unit dut (
    .clk                  (clk),
    .resetn               (resetn),
    .mem_read_from_pu     (rd),
    .mem_write_from_op    (wr),
    .addr_from_sel        (addr),
    .wdata_from_ac        (wdata),
    .clear_from_pnl       (clr),
    .mem_read_reply_to_pu (reply),
    .mem_write_done_to_op (done),
    .rdata_to_ac          (rdata),
    .busy_to_pnl          (busy),
    .err_overlap_to_pnl   (err),
    .state_to_pnl         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one request pulse for a single cycle.
  task automatic req(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    tick();
    rd = 1'b0; wr = 1'b0;
  endtask

  // Run n cycles, counting reply and done pulses.
  task automatic run(input int n, output int n_reply, output int n_done);
    n_reply = 0; n_done = 0;
    for (int i = 0; i < n; i++) begin
      if (reply) n_reply++;
      if (done) n_done++;
      tick();
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int nr, nd;
    req(1'b0, 1'b1, a, d);
    run(260, nr, nd);
  endtask

  int nr, nd, first;

  initial begin
    resetn = 1'b0;
    tick(); tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_err",   err,   0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pulse", {reply, done}, 0);
    resetn = 1'b1;

    // preload known words (array is not reset)
    do_write(12'h000, 31'h0000AAAA);
    do_write(12'h002, 31'h01234567);
    do_write(12'h010, 31'h7EADF00D);
    do_write(12'h011, 31'h0BADBEEF);

    // read 0x002 with reset released at cycle 0
    resetn = 1'b0; tick();
    resetn = 1'b1;
    req(1'b1, 1'b0, 12'h002, '0);
    nr = 0;
    for (int c = 1; c <= 8; c++) begin
      if (state != 2'd1) chk("seek_rd_state", state, 1);
      if (reply) nr++;
      tick();
    end
    chk("rd2_early_reply", nr, 0);
    chk("rd2_reply_c9", reply, 1);
    chk("rd2_rdata", rdata, 31'h01234567);
    tick();
    chk("rd2_reply_c10", reply, 0);
    chk("rd2_idle", state, 0);

    // read 0x000 at cycle 0: sector 0 already passed, full revolution
    resetn = 1'b0; tick();
    resetn = 1'b1;
    req(1'b1, 1'b0, 12'h000, '0);
    first = -1; nr = 0;
    for (int c = 1; c <= 300; c++) begin
      if (reply) begin
        nr++;
        if (first < 0) first = c;
      end
      tick();
    end
    chk("rd0_reply_cycle", first, 257);
    chk("rd0_reply_count", nr, 1);
    chk("rd0_rdata", rdata, 31'h0000AAAA);

    // write 0x5A5A5A5A to 0x043, then read it back
    req(1'b0, 1'b1, 12'h043, 31'(32'h5A5A5A5A & 32'h7FFFFFFF));
    run(260, nr, nd);
    chk("wr43_done_count", nd, 1);
    chk("wr43_no_reply", nr, 0);
    chk("wr_keeps_rdata", rdata, 31'h0000AAAA);
    req(1'b1, 1'b0, 12'h043, '0);
    run(260, nr, nd);
    chk("rd43_rdata", rdata, 31'h5A5A5A5A);

    // simultaneous read 0x010 / write 0x011
    req(1'b1, 1'b1, 12'h010, 31'h00000011);
    run(260, nr, nd);
    chk("sim_reply", nr, 1);
    chk("sim_no_done", nd, 0);
    chk("sim_rdata", rdata, 31'h7EADF00D);
    chk("sim_err", err, 1);
    req(1'b1, 1'b0, 12'h011, '0);
    run(260, nr, nd);
    chk("sim_11_unchanged", rdata, 31'h0BADBEEF);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_err0", err, 0);

    // second read while seeking is dropped
    req(1'b1, 1'b0, 12'h043, '0);
    req(1'b1, 1'b0, 12'h002, '0);
    run(260, nr, nd);
    chk("ovl_reply_count", nr, 1);
    chk("ovl_rdata", rdata, 31'h5A5A5A5A);
    chk("ovl_err", err, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovl_clr_err", err, 0);
    chk("ovl_clr_state", state, 0);

    // clear aborts a pending write
    req(1'b0, 1'b1, 12'h011, 31'h01111111);
    chk("clr_seek_wr", state, 2);
    clr = 1'b1; tick(); clr = 1'b0;
    run(260, nr, nd);
    chk("clr_no_done", nd, 0);
    req(1'b1, 1'b0, 12'h011, '0);
    run(260, nr, nd);
    chk("clr_word_kept", rdata, 31'h0BADBEEF);

    // reset during SEEK_WR aborts write
    req(1'b0, 1'b1, 12'h010, 31'h07777777);
    tick();
    chk("rst_wr_seek", state, 2);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("rstwr_state", state, 0);
    chk("rstwr_rdata", rdata, 0);
    chk("rstwr_err", err, 0);
    chk("rstwr_busy", busy, 0);
    run(260, nr, nd);
    chk("rstwr_no_pulse", nr + nd, 0);
    req(1'b1, 1'b0, 12'h010, '0);
    run(260, nr, nd);
    chk("rstwr_word_kept", rdata, 31'h7EADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_drum_unit.md
MEM_DRUM_UNIT -- requirements
Module: mem_drum_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 31, machine word width.
REQ-003 SHALL have parameter SECTOR_W, default 6, sector index width (64 sectors per revolution); sector = addr[SECTOR_W-1:0].
REQ-004 SHALL have parameter DRUM_DIV, default 4, clock cycles per sector.
REQ-005 clk  input  1  clock; all logic on posedge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 mem_read_from_pu  input  1  one-cycle read request pulse from the pulse distributor.
REQ-008 mem_write_from_op  input  1  one-cycle write request pulse.
REQ-009 addr_from_sel  input  ADDR_W  word address, sampled with a request.
REQ-010 wdata_from_ac  input  DATA_W  write data, sampled with a write request.
REQ-011 clear_from_pnl  input  1  panel clear pulse.
REQ-012 mem_read_reply_to_pu  output  1  one-cycle read-complete pulse.
REQ-013 mem_write_done_to_op  output  1  one-cycle write-complete pulse.
REQ-014 rdata_to_ac  output  DATA_W  registered read data.
REQ-015 busy_to_pnl  output  1  high when state != IDLE.
REQ-016 err_overlap_to_pnl  output  1  sticky dropped-request flag.
REQ-017 state_to_pnl  output  2  current FSM state code.

Function
REQ-018 Drum position: div_cnt counts 0..DRUM_DIV-1 every cycle and wraps; pos (SECTOR_W bits) increments, wrapping at 2^SECTOR_W-1 -> 0, in the cycle after div_cnt==DRUM_DIV-1; counters free-run, unaffected by clear_from_pnl.
REQ-019 FSM states: IDLE=0, SEEK_RD=1, SEEK_WR=2, RESP=3.
REQ-020 IDLE + read pulse: latch address, next state SEEK_RD; IDLE + write pulse (no read): latch address and wdata, next state SEEK_WR.
REQ-021 IDLE with read and write pulses in the same cycle: read accepted, write dropped, err_overlap set.
REQ-022 Any request pulse while state != IDLE: dropped, err_overlap set, operation in progress unaffected.
REQ-023 Sector match: state SEEK_* and pos == latched sector and div_cnt == 0; request entering SEEK mid-sector waits for next revolution.
REQ-024 On match in SEEK_RD: rdata_to_ac <= mem[addr] at the clock edge; next state RESP.
REQ-025 On match in SEEK_WR: mem[addr] <= latched wdata; next state RESP.
REQ-026 RESP lasts exactly one cycle: mem_read_reply_to_pu (read) or mem_write_done_to_op (write) high for that cycle only; next state IDLE; request pulse in RESP counts as overlap (REQ-022).
REQ-027 rdata_to_ac holds until the next completed read; writes do not alter it.
REQ-028 Latency: request sampled at cycle t with match first satisfied at cycle m > t -> reply high in cycle m+1; worst case 2^SECTOR_W*DRUM_DIV+1 cycles.
REQ-029 clear_from_pnl: state -> IDLE, err_overlap -> 0, pending operation aborted with no reply/done pulse and no array write; a request in the same cycle is ignored.

Reset
REQ-030 resetn low: state IDLE, div_cnt 0, pos 0, rdata_to_ac 0, err_overlap 0, both pulse outputs 0; mid-operation reset aborts with no reply and no write.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 Shared package mem_pkg: default ADDR_W/DATA_W/SECTOR_W/DRUM_DIV constants and state encoding.
REQ-033 One sub-module drum_timer (div_cnt, pos, sector_start strobe); array, FSM and latches in mem_drum_unit.

Verification
REQ-034 Reset release at cycle 0, read addr 0x002 at cycle 0 -> SEEK_RD cycles 1..8, reply high in cycle 9 only, rdata = mem[2].
REQ-035 Read addr 0x000 at cycle 0 (sector 0 passed) -> reply in cycle 257, none earlier.
REQ-036 Write 0x5A5A5A5A to addr 0x043 then read 0x043 -> done pulse once, then rdata = 0x5A5A5A5A (31-bit truncated: 0x5A5A5A5A & 0x7FFFFFFF).
REQ-037 Simultaneous read 0x010 and write 0x011 in IDLE -> read completes, mem[0x011] unchanged, err_overlap = 1.
REQ-038 Read issued, second read during SEEK_RD -> one reply only, err_overlap = 1; then clear_from_pnl -> err_overlap 0, state 0.
REQ-039 Write issued, resetn low for one cycle in SEEK_WR -> no done pulse, target word unchanged, all outputs at reset values.
